// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit for the pipelined 16-bit WISC CPU.
// Decodes the opcode in ID, then carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers. Bubbles, flush and freeze are handled
// here. A halt FSM stops fetch on HLT and lets older instructions drain.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_RUN    | normal issue; HLT reaching EX starts the drain
//   S_DRAIN  | fetch held, counter runs down while older ops retire
//   S_HALTED | processor stopped; left only through reset
module ctrl_pipe #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] id_op,
  input  logic       id_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic       freeze,
  output logic       ex_valid,
  output logic [3:0] ex_alu_op,
  output logic [1:0] ex_alu_src,
  output logic [1:0] ex_branch,
  output logic [2:0] ex_flag_en,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_hold,
  output logic       halted
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic       valid;
    logic       hlt;
    logic [3:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] branch;
    logic [2:0] flag_en;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  ctrl_t            w_dec, r_ex;
  logic             w_bubble;

  logic       r_mem_valid, r_mem_read, r_mem_write, r_mem_reg_write;
  logic [1:0] r_mem_wb_sel;
  logic       r_wb_valid, r_wb_reg_write;
  logic [1:0] r_wb_sel;

  // Opcode decode in ID
  always_comb begin
    w_dec           = '0;
    w_dec.valid     = 1'b1;
    w_dec.reg_write = (id_op <= 4'h8) || (id_op == 4'hA) || (id_op == 4'hB) || (id_op == 4'hE);
    case (id_op)
      4'h0, 4'h1: begin
        w_dec.alu_op  = id_op;
        w_dec.flag_en = 3'b111;
      end
      4'h2: begin
        w_dec.alu_op  = id_op;
        w_dec.flag_en = 3'b100;
      end
      4'h3, 4'h7: w_dec.alu_op = id_op;
      4'h4, 4'h5, 4'h6: begin
        w_dec.alu_op  = id_op;
        w_dec.alu_src = 2'b01;
        w_dec.flag_en = 3'b100;
      end
      4'h8: begin
        w_dec.alu_src  = 2'b10;
        w_dec.mem_read = 1'b1;
        w_dec.wb_sel   = 2'b01;
      end
      4'h9: begin
        w_dec.alu_src   = 2'b10;
        w_dec.mem_write = 1'b1;
      end
      4'hA: begin
        w_dec.alu_op  = 4'h8;
        w_dec.alu_src = 2'b11;
      end
      4'hB: begin
        w_dec.alu_op  = 4'h9;
        w_dec.alu_src = 2'b11;
      end
      4'hC: begin
        w_dec.alu_src = 2'b11;
        w_dec.branch  = 2'b10;
      end
      4'hD: begin
        w_dec.alu_src = 2'b11;
        w_dec.branch  = 2'b11;
      end
      4'hE: begin
        w_dec.alu_src = 2'b11;
        w_dec.wb_sel  = 2'b10;
      end
      default: begin
        w_dec.alu_src = 2'b11;
        w_dec.hlt     = 1'b1;
      end
    endcase
  end

  assign w_bubble = !id_valid || flush || stall || (r_state != S_RUN);

  // ID/EX register: bubble or decoded bundle, held under freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (!freeze) begin
      r_ex <= w_bubble ? '0 : w_dec;
    end
  end

  // EX/MEM and MEM/WB registers, held under freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_wb_sel    <= 2'b00;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_sel        <= 2'b00;
    end else if (!freeze) begin
      r_mem_valid     <= r_ex.valid;
      r_mem_read      <= r_ex.mem_read;
      r_mem_write     <= r_ex.mem_write;
      r_mem_reg_write <= r_ex.reg_write;
      r_mem_wb_sel    <= r_ex.wb_sel;
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_sel        <= r_mem_wb_sel;
    end
  end

  // Halt FSM state and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Halt FSM next state; a flush alongside HLT in EX does not cancel it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!freeze) begin
      case (r_state)
        S_RUN: begin
          if (r_ex.valid && r_ex.hlt) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) w_state_nxt = S_HALTED;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: w_state_nxt = S_HALTED;
      endcase
    end
  end

  // Halt FSM outputs
  always_comb begin
    pc_hold = stall || freeze || (r_state != S_RUN);
    halted  = (r_state == S_HALTED);
  end

  assign ex_valid     = r_ex.valid;
  assign ex_alu_op    = r_ex.alu_op;
  assign ex_alu_src   = r_ex.alu_src;
  assign ex_branch    = r_ex.branch;
  assign ex_flag_en   = r_ex.flag_en;
  assign mem_read     = r_mem_read  & r_mem_valid;
  assign mem_write    = r_mem_write & r_mem_valid;
  assign wb_reg_write = r_wb_reg_write & r_wb_valid;
  assign wb_sel       = r_wb_sel & {2{r_wb_valid}};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of ctrl_pipe decode, pipeline timing,
// bubbles, freeze, halt drain and asynchronous reset.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_op = 4'h0;
  logic       id_valid = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       freeze = 1'b0;
  logic       ex_valid;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_alu_src;
  logic [1:0] ex_branch;
  logic [2:0] ex_flag_en;
  logic       mem_read;
  logic       mem_write;
  logic       wb_reg_write;
  logic [1:0] wb_sel;
  logic       pc_hold;
  logic       halted;

  logic [18:0] all_o;
  logic [11:0] ex_o;
  int          n_chk = 0;
  int          n_err = 0;

  // {alu_op, alu_src, branch, flag_en, reg_write, wb_sel, mem_read, mem_write}
  logic [15:0] tab [16];

  ctrl_pipe #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_valid(id_valid),
    .stall(stall), .flush(flush), .freeze(freeze),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_flag_en(ex_flag_en),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_sel(wb_sel),
    .pc_hold(pc_hold), .halted(halted)
  );

  always #5 clk = ~clk;

  assign ex_o  = {ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_flag_en};
  assign all_o = {ex_o, mem_read, mem_write, wb_reg_write, wb_sel, pc_hold, halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    id_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op);
    id_op    = op;
    id_valid = 1'b1;
  endtask

  initial begin
    logic [15:0] e;
    tab[0]  = {4'h0, 2'b00, 2'b00, 3'b111, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[1]  = {4'h1, 2'b00, 2'b00, 3'b111, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[2]  = {4'h2, 2'b00, 2'b00, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[3]  = {4'h3, 2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[4]  = {4'h4, 2'b01, 2'b00, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[5]  = {4'h5, 2'b01, 2'b00, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[6]  = {4'h6, 2'b01, 2'b00, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[7]  = {4'h7, 2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[8]  = {4'h0, 2'b10, 2'b00, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0};
    tab[9]  = {4'h0, 2'b10, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1};
    tab[10] = {4'h8, 2'b11, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[11] = {4'h9, 2'b11, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0};
    tab[12] = {4'h0, 2'b11, 2'b10, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0};
    tab[13] = {4'h0, 2'b11, 2'b11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0};
    tab[14] = {4'h0, 2'b11, 2'b00, 3'b000, 1'b1, 2'b10, 1'b0, 1'b0};
    tab[15] = {4'h0, 2'b11, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0};

    // reset state
    rst_n = 1'b0;
    #3;
    chk("reset outputs", 32'(all_o), 32'h0);
    do_reset();
    chk("after reset", 32'(all_o), 32'h0);

    // single ADD through the pipe
    issue(4'h0);
    step();
    chk("add ex_alu_op", 32'(ex_alu_op), 32'h0);
    chk("add ex_flag_en", 32'(ex_flag_en), 32'h7);
    chk("add ex_valid", 32'(ex_valid), 32'h1);
    id_valid = 1'b0;
    step();
    chk("add c2 wb_reg_write", 32'(wb_reg_write), 32'h0);
    chk("add c2 mem_write", 32'(mem_write), 32'h0);
    step();
    chk("add c3 wb", 32'({wb_reg_write, wb_sel}), 32'h4);

    // all opcodes back to back
    do_reset();
    for (int k = 0; k < 19; k++) begin
      if (k < 16) issue(4'(k));
      else id_valid = 1'b0;
      step();
      if (k < 16) begin
        e = tab[k];
        chk($sformatf("sweep ex op%0h", k), 32'(ex_o), 32'({1'b1, e[15:12], e[11:10], e[9:8], e[7:5]}));
      end
      if (k >= 1 && k - 1 < 16) begin
        e = tab[k-1];
        chk($sformatf("sweep mem op%0h", k - 1), 32'({mem_read, mem_write}), 32'({e[1], e[0]}));
      end
      if (k >= 2 && k - 2 < 16) begin
        e = tab[k-2];
        chk($sformatf("sweep wb op%0h", k - 2), 32'({wb_reg_write, wb_sel}), 32'({e[4], e[3:2]}));
      end
    end

    // LW then stall, then flush+stall together
    do_reset();
    issue(4'h8);
    step();
    issue(4'h0);
    stall = 1'b1;
    step();
    chk("stall ex bubble", 32'(ex_o), 32'h0);
    chk("stall lw mem_read", 32'(mem_read), 32'h1);
    chk("stall pc_hold", 32'(pc_hold), 32'h1);
    flush = 1'b1;
    step();
    chk("flush+stall ex bubble", 32'(ex_o), 32'h0);
    chk("stall lw wb", 32'({wb_reg_write, wb_sel}), 32'h5);
    stall = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;

    // freeze with LW in MEM and ADD in WB
    do_reset();
    issue(4'h0);
    step();
    issue(4'h8);
    step();
    id_valid = 1'b0;
    step();
    chk("frz pre mem_read", 32'(mem_read), 32'h1);
    chk("frz pre wb", 32'({wb_reg_write, wb_sel}), 32'h4);
    freeze = 1'b1;
    issue(4'h9);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("frz%0d mem_read", i), 32'(mem_read), 32'h1);
      chk($sformatf("frz%0d wb", i), 32'({wb_reg_write, wb_sel}), 32'h4);
      chk($sformatf("frz%0d ex", i), 32'(ex_o), 32'h0);
    end
    freeze = 1'b0;
    id_valid = 1'b0;
    step();
    chk("frz post mem_read", 32'(mem_read), 32'h0);
    chk("frz post wb", 32'({wb_reg_write, wb_sel}), 32'h5);

    // HLT drain, flush alongside HLT in EX
    do_reset();
    issue(4'hF);
    step();
    id_valid = 1'b0;
    chk("hlt c1 pc_hold", 32'(pc_hold), 32'h0);
    chk("hlt c1 ex", 32'(ex_o), 32'({1'b1, 4'h0, 2'b11, 2'b00, 3'b000}));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("hlt c2 pc_hold", 32'(pc_hold), 32'h1);
    chk("hlt c2 halted", 32'(halted), 32'h0);
    step();
    step();
    chk("hlt c4 halted", 32'(halted), 32'h0);
    step();
    chk("hlt c5 halted", 32'(halted), 32'h1);
    issue(4'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("halted idle%0d", i), 32'(all_o), 32'h3);
    end
    id_valid = 1'b0;

    // freeze during DRAIN delays halted by the frozen cycles
    do_reset();
    issue(4'hF);
    step();
    id_valid = 1'b0;
    step();
    freeze = 1'b1;
    step();
    step();
    freeze = 1'b0;
    step();
    step();
    chk("frz drain c6 halted", 32'(halted), 32'h0);
    step();
    chk("frz drain c7 halted", 32'(halted), 32'h1);

    // async reset mid-DRAIN, then a normal ADD
    do_reset();
    issue(4'hF);
    step();
    id_valid = 1'b0;
    step();
    chk("drain pc_hold", 32'(pc_hold), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'(all_o), 32'h0);
    #2;
    rst_n = 1'b1;
    issue(4'h0);
    step();
    id_valid = 1'b0;
    chk("post-rst add ex", 32'(ex_o), 32'({1'b1, 4'h0, 2'b00, 2'b00, 3'b111}));
    step();
    step();
    chk("post-rst add wb", 32'({wb_reg_write, wb_sel}), 32'h4);
    chk("post-rst halted", 32'({pc_hold, halted}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 16-bit WISC CPU. It decodes the 4-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Bubble insertion, branch flush and global freeze are handled inside the block rather than by gating write enables at decode. A halt-drain state machine stops fetch on HLT, lets older instructions retire, and then asserts a sticky `halted`.

## Interface

Parameters:
- DRAIN_CYCLES, 3: cycles spent in DRAIN after HLT enters EX before `halted` rises; range 1..15.
- CNT_W, 4: drain counter width; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- id_op  in  4  opcode of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  load-use stall: bubble into EX; EX/MEM and MEM/WB advance.
- flush  in  1  taken branch resolved in EX: bubble into EX; has priority over `stall`.
- freeze  in  1  memory wait: every pipeline register and the FSM hold; overrides `stall` and `flush`.
- ex_valid  out  1  EX holds a non-bubble.
- ex_alu_op  out  4  ALU operation.
- ex_alu_src  out  2  00 reg, 01 zero-extended imm, 10 sign-extended imm, 11 8-bit imm.
- ex_branch  out  2  0x none, 10 B, 11 BR.
- ex_flag_en  out  3  {z,v,n} flag write enables.
- mem_read  out  1  LW in MEM.
- mem_write  out  1  SW in MEM.
- wb_reg_write  out  1  register-file write in WB.
- wb_sel  out  2  00 ALU, 01 memory, 10 next PC.
- pc_hold  out  1  hold PC and IF/ID.
- halted  out  1  processor halted; sticky.

## Operation

Opcode decode, combinational, in ID:
- Opcode map: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LHB, B LLB, C B, D BR, E PCS, F HLT.
- reg_write: opcodes 0–8, A, B, E.
- alu_src: 01 for 4–6; 10 for 8–9; 11 for A–F; otherwise 00.
- alu_op: equals the opcode for 0–7; 0 for LW and SW; 8 for LHB; 9 for LLB; 0 for all others.
- branch: 10 for C, 11 for D.
- wb_sel: 01 for LW, 10 for PCS.
- flag_en: z for 0, 1, 2, 4, 5, 6; v and n for 0 and 1.

Bubble:
- All control bits are 0 and the valid bit is 0.
- A bubble is captured into ID/EX when any of these hold: `!id_valid`, `flush`, `stall`, or FSM not RUN.

Pipeline advance:
- EX/MEM captures mem_read, mem_write, reg_write, wb_sel and valid from ID/EX.
- MEM/WB captures reg_write, wb_sel and valid.
- The registered mem/wb outputs are ANDed with their stage valid bit.

Halt FSM, states RUN, DRAIN, HALTED:
- RUN→DRAIN when EX holds a valid HLT (opcode F) and `freeze`=0. The counter loads DRAIN_CYCLES−1.
- DRAIN: the counter decrements each cycle with `freeze`=0. When it reaches 0 with `freeze`=0, go to HALTED.
- HALTED is terminal until reset.
- `flush` in the same cycle that a HLT sits in EX does not cancel the halt, because HLT is older than the branch.

pc_hold = `stall` | `freeze` | (state != RUN).

halted = (state == HALTED).

## Timing

- Reset: all pipeline registers clear to bubble, the FSM goes to RUN, the counter goes to 0, and every output is 0.
- Latency from id_op to the ex_* outputs is 1 cycle.
- mem_read and mem_write appear 2 cycles after ID; wb_reg_write and wb_sel appear 3 cycles after ID.
- `halted` rises DRAIN_CYCLES+1 unfrozen cycles after HLT is captured into EX.
- `pc_hold` rises combinationally in the cycle the FSM leaves RUN.
- `freeze` asserted for N cycles delays every event by exactly N.
- Simultaneous `freeze` with `flush` or `stall`: the freeze wins and nothing is lost. The flush or stall must still be asserted when freeze drops.
- `rst_n` falling mid-drain returns the block to RUN with an empty pipeline at once, without waiting for a clock.

## Test plan

- Reset, then ADD (0) valid: ex_alu_op=0, ex_flag_en=111. Next cycle wb_reg_write=0 and mem_write=0. Third cycle wb_reg_write=1, wb_sel=00.
- Sweep all 16 opcodes back-to-back: EX, MEM and WB outputs match the decode map at latencies of 1, 2 and 3; SW gives mem_write=1 and wb_reg_write=0; PCS gives wb_sel=10.
- LW followed by `stall` for 1 cycle: EX shows a bubble (ex_valid=0, all zero), and LW still reaches MEM with mem_read=1. `flush` and `stall` asserted together also give a bubble.
- `freeze` held 4 cycles with LW in MEM: mem_read stays 1 for 5 cycles, and WB values are unchanged during the freeze.
- HLT with DRAIN_CYCLES=3: pc_hold=1 from the cycle after HLT enters EX, halted=1 four cycles after EX capture, and halted stays 1. A subsequent valid id_op produces no control activity.
- Pulse `rst_n` low mid-DRAIN: halted=0, pc_hold=0, and all outputs are 0 immediately without a clock edge. An ADD issued afterwards completes normally.
